mult_div_unit: RTL and testbench

//  Multiply/divide unit of the pipelined MIPS core. Sits in the EX stage beside the ALU.

---
 rtl/mult_div_unit_pkg.sv | 23 ++
 rtl/mult_div_unit_md_compute.sv | 72 +++++++
 rtl/mult_div_unit.sv | 91 +++++++++
 tb/tb_mult_div_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared op-code definitions for the multiply/divide unit and the decoder that drives it.
package mult_div_unit_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  function automatic logic md_is_mult(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_md_compute.sv
// Combinational result generator: maps (op, a, b) to the {hi, lo} pair an MD op will commit.
module md_compute
  import mult_div_unit_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic [31:0]        res_hi,
  output logic [31:0]        res_lo
);

  logic        [63:0] ext_a;
  logic        [63:0] ext_b;
  logic        [63:0] prod;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic        [31:0] uq;
  logic        [31:0] ur;
  logic               is_signed;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV);

  // Low 64 bits of the extended product equal the exact signed/unsigned 64-bit result.
  assign ext_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign ext_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = ext_a * ext_b;

  assign sa = a;
  assign sb = b;

  always_comb begin
    sq = '0;
    sr = '0;
    uq = '0;
    ur = '0;
    if (b != 32'd0) begin
      uq = a / b;
      ur = a % b;
      // MIN / -1 overflows; leave it to the explicit case below.
      if (!(a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
        sq = sa / sb;
        sr = sa % sb;
      end
    end
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (md_is_mult(op)) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (md_is_div(op)) begin
      if (b == 32'd0) begin
        res_hi = a;
        res_lo = 32'hFFFF_FFFF;
      end else if (op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        res_hi = 32'd0;
        res_lo = 32'h8000_0000;
      end else if (op == MD_DIV) begin
        res_hi = sr;
        res_lo = sq;
      end else begin
        res_hi = ur;
        res_lo = uq;
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit: fixed-latency MD ops, mthi/mtlo, and the architectural HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        a,
  input  logic [31:0]        b,
  output logic               busy,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      p_hi_q, p_hi_d;
  logic [31:0]      p_lo_q, p_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      res_hi;
  logic [31:0]      res_lo;

  md_compute u_md_compute (
    .op     (op),
    .a      (a),
    .b      (b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // Latency is modelled purely by the counter; the result is captured at the start edge.
  always_comb begin
    cnt_d  = cnt_q;
    p_hi_d = p_hi_q;
    p_lo_d = p_lo_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (cnt_q == '0) begin
      if (start) begin
        if (md_is_mult(op)) begin
          p_hi_d = res_hi;
          p_lo_d = res_lo;
          cnt_d  = CNT_W'(MULT_CYCLES);
        end else if (md_is_div(op)) begin
          p_hi_d = res_hi;
          p_lo_d = res_lo;
          cnt_d  = CNT_W'(DIV_CYCLES);
        end else if (op == MD_MTHI) begin
          hi_d = a;
        end else if (op == MD_MTLO) begin
          lo_d = a;
        end
      end
    end else begin
      // A start while running is a hazard-unit failure and is deliberately ignored.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        hi_d = p_hi_q;
        lo_d = p_lo_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      p_hi_q <= '0;
      p_lo_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      p_hi_q <= p_hi_d;
      p_lo_q <= p_lo_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit with hand-computed HI/LO and busy-length expectations.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge; it is taken at the following posedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_cyc,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int n;
    old_hi = hi;
    old_lo = lo;
    issue(o, av, bv);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (n == 0) begin
        check({tag, "_hold_hi"}, hi, old_hi);
        check({tag, "_hold_lo"}, lo, old_lo);
      end
      n++;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd0;
    a      = 32'd0;
    b      = 32'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // MTHI then MTLO on back-to-back edges
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; a = 32'h1234;
    @(posedge clk); #1;
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    op = MD_MTLO; a = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; a = 32'd0;
    check("mtlo_hi", hi, 32'h1234);
    check("mtlo_lo", lo, 32'h5678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    // Reserved op is ignored
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    @(negedge clk);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", hi, 32'h1234);
    check("rsvd_lo", lo, 32'h5678);

    // Async reset mid-DIV with counter at 3
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("arst_after_busy", {31'd0, busy}, 32'd0);
    check("arst_after_hi", hi, 32'd0);
    check("arst_after_lo", lo, 32'd0);

    run_md("mult",   MD_MULT,  32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu",  MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5, 32'd2,         32'hFFFF_FFFA);
    run_md("div",    MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("divu",   MD_DIVU,  32'd7,         32'd2, 10, 32'd1,         32'd3);
    run_md("divu0",  MD_DIVU,  32'd5,         32'd0, 10, 32'd5,         32'hFFFF_FFFF);
    run_md("div0",   MD_DIV,   32'hFFFF_FFF0, 32'd0, 10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_md("divovf", MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_md("multbig", MD_MULT, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'd0);

    // Start during RUN (counter==2) must be ignored
    issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = MD_DIV; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    n = 4;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("ign_busy_cycles", 32'(n), 32'd5);
    check("ign_hi", hi, 32'd1);
    check("ign_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    check("ign_later_busy", {31'd0, busy}, 32'd0);
    check("ign_later_hi", hi, 32'd1);
    check("ign_later_lo", lo, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
